// File: rtl/victim_cache_pkg.sv
// Shared encodings for the victim cache: MESI states, lookup direction and flush FSM states.
package victim_cache_pkg;

    localparam logic [1:0] MESI_I = 2'b00;
    localparam logic [1:0] MESI_S = 2'b01;
    localparam logic [1:0] MESI_E = 2'b10;
    localparam logic [1:0] MESI_M = 2'b11;

    localparam logic RW_READ  = 1'b0;
    localparam logic RW_WRITE = 1'b1;

    typedef enum logic [1:0] {
        FL_IDLE,
        FL_SCAN,
        FL_DRAIN
    } flush_state_t;

endpackage

// File: rtl/vc_wb_buffer.sv
// One-deep writeback register with a valid/ready handshake.
// A push is only honoured while the buffer is empty; the owner guarantees that.
module vc_wb_buffer #(
    parameter int ADDR_W = 36,
    parameter int LINE_W = 128
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              i_push,
    input  logic [ADDR_W-1:0] i_push_addr,
    input  logic [LINE_W-1:0] i_push_data,
    input  logic              i_wb_rdy,
    output logic              o_wb_val,
    output logic [ADDR_W-1:0] o_wb_addr,
    output logic [LINE_W-1:0] o_wb_data
);

    logic              r_val;
    logic [ADDR_W-1:0] r_addr;
    logic [LINE_W-1:0] r_data;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_val  <= 1'b0;
            r_addr <= '0;
            r_data <= '0;
        end else if (r_val) begin
            if (i_wb_rdy) begin
                r_val <= 1'b0;
            end
        end else if (i_push) begin
            r_val  <= 1'b1;
            r_addr <= i_push_addr;
            r_data <= i_push_data;
        end
    end

    assign o_wb_val  = r_val;
    assign o_wb_addr = r_addr;
    assign o_wb_data = r_data;

endmodule

// File: rtl/victim_cache_wb.sv
// Fully associative victim cache with S1 lookup / S2 result, fill-with-eviction,
// single-entry invalidate and a flush FSM that writes back every M line.
module victim_cache_wb
    import victim_cache_pkg::*;
#(
    parameter int NUM_ENTRIES = 16,
    parameter int IDX_W       = $clog2(NUM_ENTRIES),
    parameter int ADDR_W      = 36,
    parameter int LINE_W      = 128,
    parameter int MESI_W      = 2
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              lk_val_s1,
    input  logic              lk_rw_s1,
    input  logic [ADDR_W-1:0] lk_addr_s1,
    input  logic [LINE_W-1:0] lk_wmask_s1,
    input  logic [LINE_W-1:0] lk_wdata_s1,
    output logic              lk_hit_s2,
    output logic [IDX_W-1:0]  lk_index_s2,
    output logic [MESI_W-1:0] lk_mesi_s2,
    output logic [LINE_W-1:0] lk_data_s2,
    input  logic              fill_val_s3,
    output logic              fill_rdy_s3,
    input  logic [ADDR_W-1:0] fill_addr_s3,
    input  logic [LINE_W-1:0] fill_data_s3,
    input  logic              fill_dirty_s3,
    input  logic              inv_val,
    input  logic [ADDR_W-1:0] inv_addr,
    input  logic              flush_req,
    output logic              busy,
    output logic              flush_done,
    output logic              wb_val,
    input  logic              wb_rdy,
    output logic [ADDR_W-1:0] wb_addr,
    output logic [LINE_W-1:0] wb_data
);

    localparam logic [MESI_W-1:0] L_I = MESI_W'(MESI_I);
    localparam logic [MESI_W-1:0] L_E = MESI_W'(MESI_E);
    localparam logic [MESI_W-1:0] L_M = MESI_W'(MESI_M);
    localparam logic [IDX_W-1:0]  L_LAST = IDX_W'(NUM_ENTRIES - 1);

    logic [MESI_W-1:0] r_mesi [NUM_ENTRIES];
    logic [ADDR_W-1:0] r_addr [NUM_ENTRIES];
    logic [LINE_W-1:0] r_data [NUM_ENTRIES];
    logic [IDX_W-1:0]  r_ptr;
    logic [IDX_W-1:0]  r_idx;
    flush_state_t      r_state;
    logic              r_busy;
    logic              r_done;
    logic              r_lk_hit;
    logic [IDX_W-1:0]  r_lk_idx;
    logic [MESI_W-1:0] r_lk_mesi;
    logic [LINE_W-1:0] r_lk_data;

    logic              w_wb_full;
    logic              w_fill_hit;
    logic [IDX_W-1:0]  w_fill_hit_idx;
    logic              w_inv_hit;
    logic [IDX_W-1:0]  w_inv_idx;
    logic [IDX_W-1:0]  w_tgt_idx;
    logic              w_evict;
    logic              w_fill_acc;
    logic [MESI_W-1:0] w_fill_mesi;
    logic              w_lk_hit;
    logic [IDX_W-1:0]  w_lk_idx;
    logic [MESI_W-1:0] w_lk_new_mesi;
    logic [LINE_W-1:0] w_lk_new_data;
    logic              w_scan_m;
    logic              w_scan_push;
    logic              w_push;
    logic [ADDR_W-1:0] w_push_addr;
    logic [LINE_W-1:0] w_push_data;

    always_comb begin
        w_fill_hit     = 1'b0;
        w_fill_hit_idx = '0;
        w_inv_hit      = 1'b0;
        w_inv_idx      = '0;
        for (int i = 0; i < NUM_ENTRIES; i++) begin
            if (r_mesi[i] != L_I && r_addr[i] == fill_addr_s3) begin
                w_fill_hit     = 1'b1;
                w_fill_hit_idx = IDX_W'(i);
            end
            if (r_mesi[i] != L_I && r_addr[i] == inv_addr) begin
                w_inv_hit = 1'b1;
                w_inv_idx = IDX_W'(i);
            end
        end
    end

    // A resident fill refreshes in place and never evicts; otherwise the pointer entry is replaced.
    assign w_tgt_idx   = w_fill_hit ? w_fill_hit_idx : r_ptr;
    assign w_evict     = !w_fill_hit && (r_mesi[r_ptr] == L_M);
    assign fill_rdy_s3 = (r_state == FL_IDLE) && !(w_evict && w_wb_full);
    assign w_fill_acc  = fill_val_s3 && fill_rdy_s3;
    assign w_fill_mesi = (fill_dirty_s3 || (w_fill_hit && r_mesi[w_tgt_idx] == L_M)) ? L_M : L_E;

    always_comb begin
        w_lk_hit = 1'b0;
        w_lk_idx = '0;
        if (lk_val_s1 && r_state == FL_IDLE) begin
            for (int i = 0; i < NUM_ENTRIES; i++) begin
                if (r_mesi[i] != L_I && r_addr[i] == lk_addr_s1 &&
                    !(w_fill_acc && w_tgt_idx == IDX_W'(i))) begin
                    w_lk_hit = 1'b1;
                    w_lk_idx = IDX_W'(i);
                end
            end
        end
    end

    assign w_lk_new_mesi = (lk_rw_s1 == RW_WRITE) ? L_M : r_mesi[w_lk_idx];
    assign w_lk_new_data = (lk_rw_s1 == RW_WRITE) ?
                           ((lk_wdata_s1 & lk_wmask_s1) | (r_data[w_lk_idx] & ~lk_wmask_s1)) :
                           r_data[w_lk_idx];

    assign w_scan_m    = (r_mesi[r_idx] == L_M);
    assign w_scan_push = (r_state == FL_SCAN) && w_scan_m && !w_wb_full;
    assign w_push      = (w_fill_acc && w_evict) || w_scan_push;
    assign w_push_addr = w_scan_push ? r_addr[r_idx] : r_addr[r_ptr];
    assign w_push_data = w_scan_push ? r_data[r_idx] : r_data[r_ptr];

    // Later assignments win: an invalidate overrides a write hit, a fill overrides an invalidate.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < NUM_ENTRIES; i++) begin
                r_mesi[i] <= L_I;
                r_addr[i] <= '0;
                r_data[i] <= '0;
            end
            r_ptr <= '0;
        end else begin
            if (w_lk_hit && lk_rw_s1 == RW_WRITE) begin
                r_mesi[w_lk_idx] <= L_M;
                r_data[w_lk_idx] <= w_lk_new_data;
            end
            if (w_scan_push) begin
                r_mesi[r_idx] <= L_E;
            end
            if (inv_val && w_inv_hit) begin
                r_mesi[w_inv_idx] <= L_I;
            end
            if (w_fill_acc) begin
                r_mesi[w_tgt_idx] <= w_fill_mesi;
                r_addr[w_tgt_idx] <= fill_addr_s3;
                r_data[w_tgt_idx] <= fill_data_s3;
                if (!w_fill_hit) begin
                    r_ptr <= r_ptr + 1'b1;
                end
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_lk_hit  <= 1'b0;
            r_lk_idx  <= '0;
            r_lk_mesi <= '0;
            r_lk_data <= '0;
        end else if (w_lk_hit) begin
            r_lk_hit  <= 1'b1;
            r_lk_idx  <= w_lk_idx;
            r_lk_mesi <= w_lk_new_mesi;
            r_lk_data <= w_lk_new_data;
        end else begin
            r_lk_hit  <= 1'b0;
            r_lk_idx  <= '0;
            r_lk_mesi <= '0;
            r_lk_data <= '0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= FL_IDLE;
            r_idx   <= '0;
            r_busy  <= 1'b0;
            r_done  <= 1'b0;
        end else begin
            r_done <= 1'b0;
            case (r_state)
                FL_IDLE: begin
                    if (flush_req) begin
                        r_state <= FL_SCAN;
                        r_idx   <= '0;
                        r_busy  <= 1'b1;
                    end
                end
                FL_SCAN: begin
                    if (!(w_scan_m && w_wb_full)) begin
                        if (r_idx == L_LAST) begin
                            r_state <= FL_DRAIN;
                        end else begin
                            r_idx <= r_idx + 1'b1;
                        end
                    end
                end
                FL_DRAIN: begin
                    if (!w_wb_full) begin
                        r_state <= FL_IDLE;
                        r_busy  <= 1'b0;
                        r_done  <= 1'b1;
                    end
                end
                default: begin
                    r_state <= FL_IDLE;
                    r_busy  <= 1'b0;
                end
            endcase
        end
    end

    vc_wb_buffer #(
        .ADDR_W (ADDR_W),
        .LINE_W (LINE_W)
    ) u_wb_buffer (
        .clk         (clk),
        .rst_n       (rst_n),
        .i_push      (w_push),
        .i_push_addr (w_push_addr),
        .i_push_data (w_push_data),
        .i_wb_rdy    (wb_rdy),
        .o_wb_val    (w_wb_full),
        .o_wb_addr   (wb_addr),
        .o_wb_data   (wb_data)
    );

    assign wb_val      = w_wb_full;
    assign busy        = r_busy;
    assign flush_done  = r_done;
    assign lk_hit_s2   = r_lk_hit;
    assign lk_index_s2 = r_lk_idx;
    assign lk_mesi_s2  = r_lk_mesi;
    assign lk_data_s2  = r_lk_data;

endmodule

// File: tb/tb_victim_cache_wb.sv
// Directed bench for victim_cache_wb: lookups, fills with eviction, invalidate, flush and reset abort.
module tb_victim_cache_wb;

    localparam int AW = 36;
    localparam int LW = 128;

    logic          clk;
    logic          rst_n;
    logic          lk_val_s1;
    logic          lk_rw_s1;
    logic [AW-1:0] lk_addr_s1;
    logic [LW-1:0] lk_wmask_s1;
    logic [LW-1:0] lk_wdata_s1;
    logic          lk_hit_s2;
    logic [3:0]    lk_index_s2;
    logic [1:0]    lk_mesi_s2;
    logic [LW-1:0] lk_data_s2;
    logic          fill_val_s3;
    logic          fill_rdy_s3;
    logic [AW-1:0] fill_addr_s3;
    logic [LW-1:0] fill_data_s3;
    logic          fill_dirty_s3;
    logic          inv_val;
    logic [AW-1:0] inv_addr;
    logic          flush_req;
    logic          busy;
    logic          flush_done;
    logic          wb_val;
    logic          wb_rdy;
    logic [AW-1:0] wb_addr;
    logic [LW-1:0] wb_data;

    int checkCount = 0;
    int failCount  = 0;

    victim_cache_wb dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .lk_val_s1     (lk_val_s1),
        .lk_rw_s1      (lk_rw_s1),
        .lk_addr_s1    (lk_addr_s1),
        .lk_wmask_s1   (lk_wmask_s1),
        .lk_wdata_s1   (lk_wdata_s1),
        .lk_hit_s2     (lk_hit_s2),
        .lk_index_s2   (lk_index_s2),
        .lk_mesi_s2    (lk_mesi_s2),
        .lk_data_s2    (lk_data_s2),
        .fill_val_s3   (fill_val_s3),
        .fill_rdy_s3   (fill_rdy_s3),
        .fill_addr_s3  (fill_addr_s3),
        .fill_data_s3  (fill_data_s3),
        .fill_dirty_s3 (fill_dirty_s3),
        .inv_val       (inv_val),
        .inv_addr      (inv_addr),
        .flush_req     (flush_req),
        .busy          (busy),
        .flush_done    (flush_done),
        .wb_val        (wb_val),
        .wb_rdy        (wb_rdy),
        .wb_addr       (wb_addr),
        .wb_data       (wb_data)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [LW-1:0] lineData(input int n);
        logic [31:0] w;
        w = 32'hA500_0000 + n;
        return {w, ~w, w ^ 32'h5A5A_5A5A, w};
    endfunction

    task automatic checkOutput(input string tag, input logic [LW-1:0] observed, input logic [LW-1:0] expected);
        checkCount++;
        if (observed !== expected) begin
            failCount++;
            $display("[TB] FAIL %s: got %h expected %h", tag, observed, expected);
        end
    endtask

    task automatic applyStimulus();
        @(posedge clk);
        #1;
    endtask

    task automatic clearInputs();
        lk_val_s1     = 1'b0;
        lk_rw_s1      = 1'b0;
        lk_addr_s1    = '0;
        lk_wmask_s1   = '0;
        lk_wdata_s1   = '0;
        fill_val_s3   = 1'b0;
        fill_addr_s3  = '0;
        fill_data_s3  = '0;
        fill_dirty_s3 = 1'b0;
        inv_val       = 1'b0;
        inv_addr      = '0;
        flush_req     = 1'b0;
        wb_rdy        = 1'b0;
    endtask

    task automatic resetDut();
        rst_n = 1'b0;
        clearInputs();
        applyStimulus();
        rst_n = 1'b1;
        applyStimulus();
    endtask

    task automatic checkResetOutputs(input string pfx);
        checkOutput({pfx, "_hit"},   LW'(lk_hit_s2),   '0);
        checkOutput({pfx, "_idx"},   LW'(lk_index_s2), '0);
        checkOutput({pfx, "_mesi"},  LW'(lk_mesi_s2),  '0);
        checkOutput({pfx, "_data"},  lk_data_s2,       '0);
        checkOutput({pfx, "_rdy"},   LW'(fill_rdy_s3), LW'(1));
        checkOutput({pfx, "_busy"},  LW'(busy),        '0);
        checkOutput({pfx, "_done"},  LW'(flush_done),  '0);
        checkOutput({pfx, "_wbval"}, LW'(wb_val),      '0);
        checkOutput({pfx, "_wbadr"}, LW'(wb_addr),     '0);
        checkOutput({pfx, "_wbdat"}, wb_data,          '0);
    endtask

    task automatic fillLine(input logic [AW-1:0] a, input logic [LW-1:0] d, input logic dirty);
        int waited;
        fill_val_s3   = 1'b1;
        fill_addr_s3  = a;
        fill_data_s3  = d;
        fill_dirty_s3 = dirty;
        #1;
        waited = 0;
        while (!fill_rdy_s3 && waited < 50) begin
            applyStimulus();
            waited++;
        end
        if (waited >= 50) checkOutput("fill_timeout", LW'(fill_rdy_s3), LW'(1));
        applyStimulus();
        fill_val_s3 = 1'b0;
    endtask

    task automatic lookupLine(input logic rw, input logic [AW-1:0] a, input logic [LW-1:0] m, input logic [LW-1:0] wd);
        lk_val_s1   = 1'b1;
        lk_rw_s1    = rw;
        lk_addr_s1  = a;
        lk_wmask_s1 = m;
        lk_wdata_s1 = wd;
        applyStimulus();
        lk_val_s1 = 1'b0;
    endtask

    initial begin
        logic [AW-1:0] wbA[$];
        logic [LW-1:0] wbD[$];
        logic [LW-1:0] d1;
        int doneCount;
        int cyc;

        rst_n = 1'b0;
        clearInputs();
        #2;
        checkResetOutputs("rst");
        applyStimulus();
        rst_n = 1'b1;
        applyStimulus();

        // Clean fill then read hit
        d1 = {4{32'h1111_1111}};
        fillLine(36'h100, d1, 1'b0);
        lookupLine(1'b0, 36'h100, '0, '0);
        checkOutput("t1_hit",  LW'(lk_hit_s2),   LW'(1));
        checkOutput("t1_idx",  LW'(lk_index_s2), LW'(0));
        checkOutput("t1_mesi", LW'(lk_mesi_s2),  LW'(2));
        checkOutput("t1_data", lk_data_s2,       d1);

        // Masked write hit, then clean refresh keeps M, pointer unmoved
        lookupLine(1'b1, 36'h100, 128'hFF, 128'hAB);
        checkOutput("t2_wmesi", LW'(lk_mesi_s2), LW'(3));
        checkOutput("t2_wdata", lk_data_s2,      {d1[127:8], 8'hAB});
        fillLine(36'h100, lineData(7), 1'b0);
        lookupLine(1'b0, 36'h100, '0, '0);
        checkOutput("t2_rmesi", LW'(lk_mesi_s2),  LW'(3));
        checkOutput("t2_ridx",  LW'(lk_index_s2), LW'(0));
        checkOutput("t2_rdata", lk_data_s2,       lineData(7));
        fillLine(36'h200, lineData(8), 1'b0);
        lookupLine(1'b0, 36'h200, '0, '0);
        checkOutput("t2_ptr", LW'(lk_index_s2), LW'(1));

        // Miss returns zeros
        lookupLine(1'b0, 36'h300, '0, '0);
        checkOutput("miss_hit",  LW'(lk_hit_s2), '0);
        checkOutput("miss_data", lk_data_s2,     '0);

        // Invalidate
        inv_val = 1'b1; inv_addr = 36'h200;
        applyStimulus();
        inv_val = 1'b0;
        lookupLine(1'b0, 36'h200, '0, '0);
        checkOutput("inv_hit", LW'(lk_hit_s2), '0);

        // Eviction of an M line into the writeback buffer, then back-pressure
        resetDut();
        for (int i = 0; i < 16; i++) fillLine(36'h1000 + AW'(i), lineData(i), i == 0);
        fillLine(36'h2000, lineData(32), 1'b1);
        checkOutput("t3_wbval",  LW'(wb_val),  LW'(1));
        checkOutput("t3_wbaddr", LW'(wb_addr), LW'(36'h1000));
        checkOutput("t3_wbdata", wb_data,      lineData(0));
        for (int i = 1; i < 16; i++) fillLine(36'h2000 + AW'(i), lineData(32 + i), 1'b0);
        fill_val_s3 = 1'b1; fill_addr_s3 = 36'h3000; fill_data_s3 = lineData(48); fill_dirty_s3 = 1'b0;
        #1;
        checkOutput("t3_stall0", LW'(fill_rdy_s3), '0);
        applyStimulus();
        checkOutput("t3_stall1", LW'(fill_rdy_s3), '0);
        checkOutput("t3_hold",   LW'(wb_addr),     LW'(36'h1000));
        wb_rdy = 1'b1;
        applyStimulus();
        wb_rdy = 1'b0;
        #1;
        checkOutput("t3_drained", LW'(wb_val),      '0);
        checkOutput("t3_rdyback", LW'(fill_rdy_s3), LW'(1));
        applyStimulus();
        fill_val_s3 = 1'b0;
        checkOutput("t3_wbval2",  LW'(wb_val),  LW'(1));
        checkOutput("t3_wbaddr2", LW'(wb_addr), LW'(36'h2000));
        checkOutput("t3_wbdata2", wb_data,      lineData(32));
        lookupLine(1'b0, 36'h3000, '0, '0);
        checkOutput("t3_newidx",  LW'(lk_index_s2), LW'(0));
        checkOutput("t3_newmesi", LW'(lk_mesi_s2),  LW'(2));

        // Lookup of the entry a same-cycle fill is replacing
        resetDut();
        for (int i = 0; i < 16; i++) fillLine(36'h6000 + AW'(i), lineData(i), 1'b0);
        for (int i = 0; i < 3; i++) fillLine(36'h6100 + AW'(i), lineData(20 + i), 1'b0);
        lk_val_s1 = 1'b1; lk_rw_s1 = 1'b0; lk_addr_s1 = 36'h6003;
        fill_val_s3 = 1'b1; fill_addr_s3 = 36'h6200; fill_data_s3 = lineData(40); fill_dirty_s3 = 1'b0;
        applyStimulus();
        lk_val_s1 = 1'b0; fill_val_s3 = 1'b0;
        checkOutput("t4_hit", LW'(lk_hit_s2), '0);
        lookupLine(1'b0, 36'h6200, '0, '0);
        checkOutput("t4_newidx", LW'(lk_index_s2), LW'(3));

        // Flush with three M entries and toggling wb_rdy
        resetDut();
        for (int i = 0; i < 16; i++) fillLine(36'h4000 + AW'(i), lineData(i), (i == 1) || (i == 5) || (i == 9));
        flush_req = 1'b1;
        applyStimulus();
        flush_req = 1'b0;
        checkOutput("t5_busy", LW'(busy), LW'(1));
        lk_val_s1 = 1'b1; lk_rw_s1 = 1'b0; lk_addr_s1 = 36'h4000;
        applyStimulus();
        lk_val_s1 = 1'b0;
        checkOutput("t5_lkmiss", LW'(lk_hit_s2), '0);
        doneCount = 0;
        for (int c = 0; c < 200; c++) begin
            cyc = c;
            wb_rdy = cyc[0];
            #1;
            if (wb_val && wb_rdy) begin
                wbA.push_back(wb_addr);
                wbD.push_back(wb_data);
            end
            if (flush_done) doneCount++;
            applyStimulus();
        end
        wb_rdy = 1'b0;
        checkOutput("t5_wbcount", LW'(wbA.size()), LW'(3));
        if (wbA.size() == 3) begin
            checkOutput("t5_wba0", LW'(wbA[0]), LW'(36'h4001));
            checkOutput("t5_wba1", LW'(wbA[1]), LW'(36'h4005));
            checkOutput("t5_wba2", LW'(wbA[2]), LW'(36'h4009));
            checkOutput("t5_wbd1", wbD[1], lineData(5));
        end
        checkOutput("t5_done",  LW'(doneCount), LW'(1));
        checkOutput("t5_idle",  LW'(busy),      '0);
        lookupLine(1'b0, 36'h4005, '0, '0);
        checkOutput("t5_mesi5", LW'(lk_mesi_s2), LW'(2));
        lookupLine(1'b0, 36'h4009, '0, '0);
        checkOutput("t5_mesi9", LW'(lk_mesi_s2), LW'(2));

        // Reset in the middle of a flush
        resetDut();
        fillLine(36'h5000, lineData(60), 1'b1);
        fillLine(36'h5001, lineData(61), 1'b1);
        flush_req = 1'b1;
        applyStimulus();
        flush_req = 1'b0;
        applyStimulus();
        checkOutput("t6_busy",  LW'(busy),   LW'(1));
        checkOutput("t6_wbval", LW'(wb_val), LW'(1));
        rst_n = 1'b0;
        #1;
        checkResetOutputs("t6rst");
        applyStimulus();
        rst_n = 1'b1;
        doneCount = 0;
        for (int c = 0; c < 10; c++) begin
            if (flush_done) doneCount++;
            applyStimulus();
        end
        checkOutput("t6_nodone", LW'(doneCount), '0);
        lookupLine(1'b0, 36'h5000, '0, '0);
        checkOutput("t6_miss0", LW'(lk_hit_s2), '0);
        lookupLine(1'b0, 36'h5001, '0, '0);
        checkOutput("t6_miss1", LW'(lk_hit_s2), '0);

        $display("TB_RESULT checks=%0d failures=%0d", checkCount, failCount);
        $finish;
    end

endmodule
